// File: rtl/reservation_station_pkg.sv
// Shared widths, constants and opcode encodings for the ALU reservation station.
package reservation_station_pkg;

    localparam int unsigned OpcodeLength = 6;
    localparam int unsigned DataLength   = 32;
    localparam int unsigned PcLength     = 32;
    localparam int unsigned TagLength    = 4;
    localparam int unsigned RsSize       = 16;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;
    localparam logic [DataLength-1:0] Zero = '0;

    // Opcode 0 is reserved as "no operation" on the ALU issue port.
    localparam logic [OpcodeLength-1:0] OpLui   = 6'd1;
    localparam logic [OpcodeLength-1:0] OpAuipc = 6'd2;
    localparam logic [OpcodeLength-1:0] OpJal   = 6'd3;
    localparam logic [OpcodeLength-1:0] OpJalr  = 6'd4;
    localparam logic [OpcodeLength-1:0] OpBeq   = 6'd5;
    localparam logic [OpcodeLength-1:0] OpBne   = 6'd6;
    localparam logic [OpcodeLength-1:0] OpBlt   = 6'd7;
    localparam logic [OpcodeLength-1:0] OpBge   = 6'd8;
    localparam logic [OpcodeLength-1:0] OpBltu  = 6'd9;
    localparam logic [OpcodeLength-1:0] OpBgeu  = 6'd10;
    localparam logic [OpcodeLength-1:0] OpLb    = 6'd11;
    localparam logic [OpcodeLength-1:0] OpLh    = 6'd12;
    localparam logic [OpcodeLength-1:0] OpLw    = 6'd13;
    localparam logic [OpcodeLength-1:0] OpLbu   = 6'd14;
    localparam logic [OpcodeLength-1:0] OpLhu   = 6'd15;
    localparam logic [OpcodeLength-1:0] OpSb    = 6'd16;
    localparam logic [OpcodeLength-1:0] OpSh    = 6'd17;
    localparam logic [OpcodeLength-1:0] OpSw    = 6'd18;
    localparam logic [OpcodeLength-1:0] OpAddi  = 6'd19;
    localparam logic [OpcodeLength-1:0] OpSlti  = 6'd20;
    localparam logic [OpcodeLength-1:0] OpSltiu = 6'd21;
    localparam logic [OpcodeLength-1:0] OpXori  = 6'd22;
    localparam logic [OpcodeLength-1:0] OpOri   = 6'd23;
    localparam logic [OpcodeLength-1:0] OpAndi  = 6'd24;
    localparam logic [OpcodeLength-1:0] OpSlli  = 6'd25;
    localparam logic [OpcodeLength-1:0] OpSrli  = 6'd26;
    localparam logic [OpcodeLength-1:0] OpSrai  = 6'd27;
    localparam logic [OpcodeLength-1:0] OpAdd   = 6'd28;
    localparam logic [OpcodeLength-1:0] OpSub   = 6'd29;
    localparam logic [OpcodeLength-1:0] OpSll   = 6'd30;
    localparam logic [OpcodeLength-1:0] OpSlt   = 6'd31;
    localparam logic [OpcodeLength-1:0] OpSltu  = 6'd32;
    localparam logic [OpcodeLength-1:0] OpXor   = 6'd33;
    localparam logic [OpcodeLength-1:0] OpSrl   = 6'd34;
    localparam logic [OpcodeLength-1:0] OpSra   = 6'd35;
    localparam logic [OpcodeLength-1:0] OpOr    = 6'd36;
    localparam logic [OpcodeLength-1:0] OpAnd   = 6'd37;

endpackage

// File: rtl/reservation_station_priority_select.sv
// Lowest-index set-bit encoder: returns the index of the first set request bit.
module rs_priority_select
    import reservation_station_pkg::*;
#(
    parameter int unsigned Width = RsSize,
    parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] req,
    output logic [IdxW-1:0]  idx,
    output logic             found
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = False;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IdxW'(i);
                found = True;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU-side reservation station: holds dispatched instructions until both
// operands resolve via CDB snooping, then issues one per cycle by index priority.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RsSize,
    parameter int unsigned TAG_W   = TagLength,
    parameter int unsigned OP_W    = OpcodeLength,
    parameter int unsigned DATA_W  = DataLength
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              dispatch_valid,
    input  logic [OP_W-1:0]   dispatch_op,
    input  logic              dispatch_q1_busy,
    input  logic [TAG_W-1:0]  dispatch_q1,
    input  logic [DATA_W-1:0] dispatch_v1,
    input  logic              dispatch_q2_busy,
    input  logic [TAG_W-1:0]  dispatch_q2,
    input  logic [DATA_W-1:0] dispatch_v2,
    input  logic [DATA_W-1:0] dispatch_imm,
    input  logic [DATA_W-1:0] dispatch_pc,
    input  logic [TAG_W-1:0]  dispatch_dest,
    output logic              full_to_dispatcher,
    input  logic              alu_cdb_valid,
    input  logic [TAG_W-1:0]  alu_cdb_tag,
    input  logic [DATA_W-1:0] alu_cdb_data,
    input  logic              lsb_cdb_valid,
    input  logic [TAG_W-1:0]  lsb_cdb_tag,
    input  logic [DATA_W-1:0] lsb_cdb_data,
    output logic [OP_W-1:0]   op_to_alu,
    output logic [DATA_W-1:0] v1_to_alu,
    output logic [DATA_W-1:0] v2_to_alu,
    output logic [DATA_W-1:0] imm_to_alu,
    output logic [DATA_W-1:0] pc_to_alu,
    output logic [TAG_W-1:0]  dest_to_alu,
    output logic              is_empty_to_alu
);

    localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] q1_busy_q, q1_busy_d;
    logic [RS_SIZE-1:0] q2_busy_q, q2_busy_d;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [OP_W-1:0]    op_d   [RS_SIZE];
    logic [TAG_W-1:0]   q1_q   [RS_SIZE];
    logic [TAG_W-1:0]   q1_d   [RS_SIZE];
    logic [TAG_W-1:0]   q2_q   [RS_SIZE];
    logic [TAG_W-1:0]   q2_d   [RS_SIZE];
    logic [DATA_W-1:0]  v1_q   [RS_SIZE];
    logic [DATA_W-1:0]  v1_d   [RS_SIZE];
    logic [DATA_W-1:0]  v2_q   [RS_SIZE];
    logic [DATA_W-1:0]  v2_d   [RS_SIZE];
    logic [DATA_W-1:0]  imm_q  [RS_SIZE];
    logic [DATA_W-1:0]  imm_d  [RS_SIZE];
    logic [DATA_W-1:0]  pc_q   [RS_SIZE];
    logic [DATA_W-1:0]  pc_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];

    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [DATA_W-1:0] out_v1_q, out_v1_d;
    logic [DATA_W-1:0] out_v2_q, out_v2_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic [DATA_W-1:0] out_pc_q, out_pc_d;
    logic [TAG_W-1:0]  out_dest_q, out_dest_d;
    logic              empty_q, empty_d;

    logic [RS_SIZE-1:0] free_vec, ready_vec;
    logic [IdxW-1:0]    free_idx, issue_idx;
    logic               free_found, issue_found;
    logic               full;

    assign free_vec  = ~busy_q;
    assign ready_vec = busy_q & ~q1_busy_q & ~q2_busy_q;
    assign full      = ~free_found;

    rs_priority_select #(
        .Width (RS_SIZE),
        .IdxW  (IdxW)
    ) u_free_select (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_select #(
        .Width (RS_SIZE),
        .IdxW  (IdxW)
    ) u_issue_select (
        .req   (ready_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    // Returns {still_pending, value}; the ALU bus wins if both buses match.
    function automatic logic [DATA_W:0] snoop(input logic pend, input logic [TAG_W-1:0] tag,
                                              input logic [DATA_W-1:0] val);
        logic [DATA_W:0] res;
        res = {pend, val};
        if (pend && alu_cdb_valid && alu_cdb_tag == tag) begin
            res = {False, alu_cdb_data};
        end else if (pend && lsb_cdb_valid && lsb_cdb_tag == tag) begin
            res = {False, lsb_cdb_data};
        end
        return res;
    endfunction

    always_comb begin
        busy_d     = busy_q;
        q1_busy_d  = q1_busy_q;
        q2_busy_d  = q2_busy_q;
        op_d       = op_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        dest_d     = dest_q;
        out_op_d   = out_op_q;
        out_v1_d   = out_v1_q;
        out_v2_d   = out_v2_q;
        out_imm_d  = out_imm_q;
        out_pc_d   = out_pc_q;
        out_dest_d = out_dest_q;
        empty_d    = empty_q;

        if (rst || clear) begin
            busy_d     = '0;
            out_op_d   = '0;
            out_v1_d   = Zero;
            out_v2_d   = Zero;
            out_imm_d  = Zero;
            out_pc_d   = Zero;
            out_dest_d = '0;
            empty_d    = True;
        end else if (!rdy) begin
            // Outputs hold, but the ALU must not see the held instruction again.
            empty_d = True;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (busy_q[i]) begin
                    {q1_busy_d[i], v1_d[i]} = snoop(q1_busy_q[i], q1_q[i], v1_q[i]);
                    {q2_busy_d[i], v2_d[i]} = snoop(q2_busy_q[i], q2_q[i], v2_q[i]);
                end
            end

            if (issue_found) begin
                busy_d[issue_idx] = False;
                out_op_d          = op_q[issue_idx];
                out_v1_d          = v1_q[issue_idx];
                out_v2_d          = v2_q[issue_idx];
                out_imm_d         = imm_q[issue_idx];
                out_pc_d          = pc_q[issue_idx];
                out_dest_d        = dest_q[issue_idx];
                empty_d           = False;
            end else begin
                out_op_d = '0;
                empty_d  = True;
            end

            // Free slot is chosen from registered busy bits, so a slot being
            // issued this cycle is never reused in the same cycle.
            if (dispatch_valid && !full) begin
                busy_d[free_idx] = True;
                op_d[free_idx]   = dispatch_op;
                q1_d[free_idx]   = dispatch_q1;
                q2_d[free_idx]   = dispatch_q2;
                imm_d[free_idx]  = dispatch_imm;
                pc_d[free_idx]   = dispatch_pc;
                dest_d[free_idx] = dispatch_dest;
                {q1_busy_d[free_idx], v1_d[free_idx]} =
                    snoop(dispatch_q1_busy, dispatch_q1, dispatch_v1);
                {q2_busy_d[free_idx], v2_d[free_idx]} =
                    snoop(dispatch_q2_busy, dispatch_q2, dispatch_v2);
            end
        end
    end

    always_ff @(posedge clk) begin
        busy_q     <= busy_d;
        q1_busy_q  <= q1_busy_d;
        q2_busy_q  <= q2_busy_d;
        op_q       <= op_d;
        q1_q       <= q1_d;
        q2_q       <= q2_d;
        v1_q       <= v1_d;
        v2_q       <= v2_d;
        imm_q      <= imm_d;
        pc_q       <= pc_d;
        dest_q     <= dest_d;
        out_op_q   <= out_op_d;
        out_v1_q   <= out_v1_d;
        out_v2_q   <= out_v2_d;
        out_imm_q  <= out_imm_d;
        out_pc_q   <= out_pc_d;
        out_dest_q <= out_dest_d;
        empty_q    <= empty_d;
    end

    assign full_to_dispatcher = full;
    assign op_to_alu          = out_op_q;
    assign v1_to_alu          = out_v1_q;
    assign v2_to_alu          = out_v2_q;
    assign imm_to_alu         = out_imm_q;
    assign pc_to_alu          = out_pc_q;
    assign dest_to_alu        = out_dest_q;
    assign is_empty_to_alu    = empty_q;

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
ALU-side reservation station of the Tomasulo core.
- Buffers dispatched instructions until both source operands are resolved.
- Snoops the two result broadcast buses (ALU and load/store buffer) to wake operands.
- Issues at most one ready instruction per cycle to the combinational ALU, driving its op/v1/v2/imm/pc/is_empty inputs from registers.
- Forwards the destination ROB tag alongside the issued instruction so the ALU result can be retired.

Parameters:
RS_SIZE, 16, number of entries (power of two)
TAG_W, 4, ROB tag width; log2 of ROB depth
OP_W, 6, internal opcode width (matches shared opcode encoding)
DATA_W, 32, operand/immediate/pc width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low = stall (no state change)
clear  in  1  misprediction flush; discard all entries
dispatch_valid  in  1  new instruction present this cycle
dispatch_op  in  OP_W  opcode
dispatch_q1_busy  in  1  operand 1 pending (value not yet produced)
dispatch_q1  in  TAG_W  ROB tag producing operand 1
dispatch_v1  in  DATA_W  operand 1 value (valid when not busy)
dispatch_q2_busy  in  1  operand 2 pending
dispatch_q2  in  TAG_W  ROB tag producing operand 2
dispatch_v2  in  DATA_W  operand 2 value
dispatch_imm  in  DATA_W  raw immediate
dispatch_pc  in  DATA_W  instruction pc
dispatch_dest  in  TAG_W  destination ROB tag
full_to_dispatcher  out  1  no free entry
alu_cdb_valid  in  1  ALU broadcast valid
alu_cdb_tag  in  TAG_W  ALU broadcast tag
alu_cdb_data  in  DATA_W  ALU broadcast value
lsb_cdb_valid  in  1  load/store broadcast valid
lsb_cdb_tag  in  TAG_W  load/store broadcast tag
lsb_cdb_data  in  DATA_W  load/store broadcast value
op_to_alu  out  OP_W  issued opcode
v1_to_alu  out  DATA_W  issued operand 1
v2_to_alu  out  DATA_W  issued operand 2
imm_to_alu  out  DATA_W  issued immediate
pc_to_alu  out  DATA_W  issued pc
dest_to_alu  out  TAG_W  issued ROB tag
is_empty_to_alu  out  1  high = no instruction issued this cycle

Behaviour:
Entry state:
- Each entry holds busy, op, q1_busy, q1, v1, q2_busy, q2, v2, imm, pc, dest.

Reset:
- rst or clear at a clock edge clears every busy bit and all output registers to 0, with is_empty_to_alu = 1.
- clear overrides dispatch, wakeup and issue in the same cycle. rst has priority over everything.

Stall:
- rdy = 0 freezes all entries.
- is_empty_to_alu is driven 1 so the ALU does not re-finish a held instruction. The other outputs hold their values.

Full flag:
- full_to_dispatcher is combinational: 1 when all RS_SIZE entries are busy.
- An entry freed by issue in the same cycle does not count as free.
- dispatch_valid while full is ignored; the dispatcher must not do this.

Dispatch (rdy = 1, not full):
- The lowest-index free entry is written at the edge.
- Same-cycle capture: if an operand is busy and its tag matches a valid CDB broadcast this cycle, the entry stores the CDB data with that operand marked not busy.
- If both CDBs match, the ALU bus wins; a correct ROB never produces this case.

Wakeup:
- Every busy entry with a pending operand whose tag equals a valid CDB tag captures the data and clears its pending bit at the edge.
- The two operands are handled independently.

Issue:
- Candidates are entries that were busy with both operands ready at the start of the cycle (registered state only).
- The lowest-index candidate is selected. At the edge its fields load the output registers, is_empty_to_alu = 0, and its busy bit clears.
- No candidate: is_empty_to_alu = 1; op_to_alu is driven 0, other outputs hold.

Latency:
- Dispatch with both operands ready: issue outputs valid 1 cycle later, i.e. 2 edges after dispatch_valid is sampled.
- CDB wakeup: the woken entry issues no earlier than the cycle after capture.

Ordering:
- There is no age ordering; index priority only.
- The ALU is fully pipelined-combinational, so there is no backpressure from the ALU.

Decomposition:
- Shared parameters include file holds:
  - opcode encodings (LUI…AND)
  - widths (OpcodeLength, DataLength, PcLength, TagLength)
  - True/False/Zero constants
  - RS_SIZE
- One sub-module, rs_priority_select: parameterised lowest-index-set-bit encoder over an RS_SIZE-bit vector, returning index and found flag.
- It is instanced twice: once for the free-slot search, once for the ready-entry search.

Test Plan:
- Reset/empty: hold rst 2 cycles, then idle → is_empty_to_alu = 1, full_to_dispatcher = 0, op_to_alu = 0.
- Ready dispatch: ADD v1 = 5, v2 = 7, dest = 3, both ready → two edges later op = ADD, v1 = 5, v2 = 7, dest = 3, is_empty = 0; next cycle is_empty = 1.
- Wakeup: SUB with q1 busy (tag 6) and v2 = 1; three idle cycles (no issue); lsb_cdb tag 6 data 0x10 → SUB issues the cycle after capture with v1 = 0x10, v2 = 1.
- Same-cycle capture: dispatch ADDI with q1 busy tag 2 while alu_cdb tag 2 data 9 is valid → issues 2 edges later with v1 = 9, imm as dispatched.
- Full/priority: fill 16 entries all waiting on tag 1 → full = 1 and extra dispatch dropped; broadcast tag 1 → entries issue in index order 0..15 on consecutive cycles; full drops after the first issue.
- Flush and stall:
  - Fill 4 ready entries, assert clear together with dispatch_valid → no further issue, full = 0, dispatched entry discarded.
  - rdy = 0 for 3 cycles with a ready entry → is_empty = 1 throughout; issue occurs the first cycle after rdy returns.
